// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues one command at a time to an external combinational ALU and queues results in a FWFT FIFO.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_fn,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_fn,
  input  logic [7:0]       alu_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_z,
  output logic [TAG_W-1:0] res_tag,
  output logic [3:0]       res_fn,
  output logic             res_dz,
  output logic [15:0]      op_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 8 + TAG_W + 5;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [7:0]       a_q, b_q;
  logic [3:0]       fn_q;
  logic [TAG_W-1:0] tag_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      ops_q;
  logic             rdy_q, rdy_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic             accept, push, pop, dz;
  assign accept  = cmd_valid & rdy_q;
  assign push    = state_q == EXEC;
  assign pop     = res_valid & res_ready;
  assign dz      = fn_q == 4'b0011 && b_q == 8'd0;
  assign state_d = accept ? EXEC : IDLE;
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
  // ready is registered from next state so it never depends on cmd_valid combinationally
  assign rdy_d   = state_d == IDLE && cnt_d < CW'(DEPTH);
  assign cmd_ready = rdy_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_fn    = fn_q;
  assign op_count  = ops_q;
  assign res_valid = cnt_q != '0;
  assign {res_z, res_tag, res_fn, res_dz} = res_valid ? mem_q[rd_q] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fn_q    <= '0;
      tag_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        fn_q  <= cmd_fn;
        tag_q <= cmd_tag;
      end
      if (push) begin
        wr_q  <= wr_q + AW'(1);
        ops_q <= ops_q + 16'd1;
      end
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end
  // storage needs no reset: outputs are gated by res_valid and the count is flushed
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= {alu_z, tag_q, fn_q, dz};
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: randomized and directed checks of alu_cmd_issuer against a queue-based model.
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  logic clk = 0, rst = 1, cmd_valid = 0, res_ready = 0;
  logic cmd_ready, res_valid, res_dz;
  logic [7:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_z, res_z;
  logic [3:0] cmd_fn = 0, alu_fn, res_fn;
  logic [TAG_W-1:0] cmd_tag = 0, res_tag;
  logic [15:0] op_count;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fn(cmd_fn), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
    .res_tag(res_tag), .res_fn(res_fn), .res_dz(res_dz), .op_count(op_count)
  );
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
    case (fn)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return 8'(a * b);
      4'd3:    return b == 0 ? 8'hFF : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd15:   return 8'($countones(a));
      default: return a ^ 8'h5A ^ b;
    endcase
  endfunction
  always_comb alu_z = alu_f(alu_a, alu_b, alu_fn);
  typedef struct {logic [7:0] z; logic [TAG_W-1:0] tag; logic [3:0] fn; logic dz;} res_t;
  res_t q[$];
  logic m_pend = 0, m_ready = 0, m_acc;
  logic [7:0] m_a = 0, m_b = 0;
  logic [3:0] m_fn = 0;
  logic [TAG_W-1:0] m_tag = 0;
  logic [15:0] m_ops = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_pend = 0; m_ready = 0; m_a = 0; m_b = 0; m_fn = 0; m_tag = 0; m_ops = 0;
    end else begin
      m_acc = cmd_valid && m_ready;
      if (res_ready && q.size() > 0) void'(q.pop_front());
      if (m_pend) begin
        q.push_back('{alu_f(m_a, m_b, m_fn), m_tag, m_fn, m_fn == 4'd3 && m_b == 0});
        m_ops++;
      end
      if (m_acc) begin
        m_a = cmd_a; m_b = cmd_b; m_fn = cmd_fn; m_tag = cmd_tag;
      end
      m_pend = m_acc;
      m_ready = !m_acc && q.size() < DEPTH;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    chk("res_valid", 32'(res_valid), 32'(q.size() > 0));
    chk("op_count", 32'(op_count), 32'(m_ops));
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("alu_fn", 32'(alu_fn), 32'(m_fn));
    if (q.size() > 0) begin
      chk("res_z", 32'(res_z), 32'(q[0].z));
      chk("res_tag", 32'(res_tag), 32'(q[0].tag));
      chk("res_fn", 32'(res_fn), 32'(q[0].fn));
      chk("res_dz", 32'(res_dz), 32'(q[0].dz));
    end else if (rst) begin
      chk("rst_res_z", 32'(res_z), 0);
      chk("rst_res_tag", 32'(res_tag), 0);
      chk("rst_res_fn", 32'(res_fn), 0);
      chk("rst_res_dz", 32'(res_dz), 0);
    end
  end
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn, input logic [TAG_W-1:0] tag);
    int n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 1);
    cmd_a = a; cmd_b = b; cmd_fn = fn; cmd_tag = tag; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic pop1();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_ops", 32'(op_count), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 1);
    send(8'h0C, 8'h05, 4'h0, 4'd3);
    chk("add_busy", 32'(cmd_ready), 0);
    chk("add_early_valid", 32'(res_valid), 0);
    @(negedge clk);
    chk("add_valid", 32'(res_valid), 1);
    chk("add_z", 32'(res_z), 32'h11);
    chk("add_tag", 32'(res_tag), 3);
    chk("add_dz", 32'(res_dz), 0);
    chk("add_ops", 32'(op_count), 1);
    pop1();
    send(8'h0C, 8'h33, 4'hF, 4'd5);
    @(negedge clk);
    chk("hw_z", 32'(res_z), 2);
    chk("hw_fn", 32'(res_fn), 32'hF);
    pop1();
    send(8'h0C, 8'h00, 4'h3, 4'd6);
    @(negedge clk);
    chk("div0_dz", 32'(res_dz), 1);
    chk("div0_z", 32'(res_z), 32'hFF);
    pop1();
    send(8'h0C, 8'h05, 4'h3, 4'd7);
    @(negedge clk);
    chk("div_dz", 32'(res_dz), 0);
    chk("div_z", 32'(res_z), 2);
    pop1();
    send(8'h01, 8'h02, 4'h0, 4'd8);
    @(negedge clk);
    send(8'h10, 8'h20, 4'h0, 4'd9);
    res_ready = 1;
    @(negedge clk);
    chk("pp_valid", 32'(res_valid), 1);
    chk("pp_tag", 32'(res_tag), 9);
    chk("pp_z", 32'(res_z), 32'h30);
    @(negedge clk);
    chk("pp_empty", 32'(res_valid), 0);
    res_ready = 0;
    for (int t = 0; t < 4; t++) send(8'(t), 8'h01, 4'h0, TAG_W'(t));
    @(negedge clk);
    chk("fill_ready", 32'(cmd_ready), 0);
    cmd_a = 8'h04; cmd_b = 8'h01; cmd_fn = 4'h0; cmd_tag = 4'd4; cmd_valid = 1;
    repeat (2) @(negedge clk);
    chk("full_blocked", 32'(cmd_ready), 0);
    chk("fill_head", 32'(res_tag), 0);
    pop1();
    chk("ready_after_pop", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 0;
    res_ready = 1;
    for (int i = 1; i < 5; i++) begin
      int n = 0;
      while (!res_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("drain_valid", 32'(res_valid), 1);
      chk("drain_tag", 32'(res_tag), i);
      @(negedge clk);
    end
    chk("drain_empty", 32'(res_valid), 0);
    res_ready = 0;
    send(8'h01, 8'h01, 4'h0, 4'd10);
    @(negedge clk);
    send(8'h02, 8'h02, 4'h0, 4'd11);
    @(negedge clk);
    send(8'h03, 8'h03, 4'h0, 4'd12);
    #1 rst = 1;
    #2 rst = 0;
    #1;
    chk("midrst_valid", 32'(res_valid), 0);
    chk("midrst_ops", 32'(op_count), 0);
    chk("midrst_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("midrst_ready_back", 32'(cmd_ready), 1);
    send(8'h04, 8'h04, 4'h0, 4'd13);
    @(negedge clk);
    chk("midrst_ops_after", 32'(op_count), 1);
    chk("midrst_z_after", 32'(res_z), 8);
    for (int i = 0; i < 800; i++) begin
      cmd_valid = 1'($urandom);
      cmd_a = 8'($urandom);
      cmd_b = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
      cmd_fn = 4'($urandom);
      cmd_tag = TAG_W'($urandom);
      res_ready = (i % 200 < 100) ? ($urandom % 4 == 0) : ($urandom % 3 != 0);
      @(negedge clk);
    end
    cmd_valid = 0;
    res_ready = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the result FIFO entry count (power of two, at least 2).
REQ-002 The block SHALL have parameter TAG_W, default 4, giving the command tag width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-008 The block SHALL have ports cmd_a and cmd_b, input, 8 bits each: the operands.
REQ-009 The block SHALL have port cmd_fn, input, 4 bits: the ALU function code.
REQ-010 The block SHALL have port cmd_tag, input, TAG_W bits: the command identifier.
REQ-011 The block SHALL have ports alu_a and alu_b (output, 8 bits each) and alu_fn (output, 4 bits), which drive the external combinational ALU.
REQ-012 The block SHALL have port alu_z, input, 8 bits: the external ALU result.
REQ-013 The block SHALL have port res_valid, output, 1 bit: the FIFO head is valid.
REQ-014 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the head.
REQ-015 The block SHALL have ports res_z (output, 8 bits), res_tag (output, TAG_W bits) and res_fn (output, 4 bits): the result, tag and function code of the FIFO head.
REQ-016 The block SHALL have port res_dz, output, 1 bit: the FIFO head was a divide (fn 0011) with b equal to 0.
REQ-017 The block SHALL have port op_count, output, 16 bits: the number of results written to the FIFO, wrapping.

Function
REQ-018 The FSM SHALL have two states: IDLE and EXEC.
REQ-019 cmd_ready SHALL equal (state==IDLE) AND (fifo_count < DEPTH), and SHALL be registered-state-derived only, with no combinational path from cmd_valid.
REQ-020 When cmd_valid and cmd_ready are both high at a clock edge, the block SHALL latch cmd_a, cmd_b, cmd_fn and cmd_tag, drive the latched a, b and fn onto alu_a, alu_b and alu_fn, and go to EXEC.
REQ-021 alu_a, alu_b and alu_fn SHALL hold their last values at all times other than command acceptance; they SHALL NOT change while in EXEC.
REQ-022 On the edge that ends EXEC, the block SHALL write {alu_z, tag, fn, dz} into the FIFO, increment op_count (mod 2^16), and return to IDLE.
REQ-023 Latency SHALL be: command accepted at edge k, result written at edge k+1, and res_valid high after edge k+1 if the FIFO was empty.
REQ-024 Throughput SHALL be at most one command per 2 cycles.
REQ-025 dz SHALL be computed as (fn==4'b0011 and b==0); alu_z SHALL be stored unmodified regardless of dz.
REQ-026 The FIFO SHALL be first-word-fall-through: res_* presents the head whenever res_valid is high, and the head is popped at an edge where res_valid and res_ready are both high.
REQ-027 res_z, res_tag, res_fn and res_dz SHALL hold stable while res_valid is high and res_ready is low.
REQ-028 A simultaneous FIFO push and pop SHALL leave the FIFO count unchanged and preserve order.
REQ-029 A pop when the FIFO is empty SHALL have no effect.
REQ-030 A command is never accepted while the FIFO is full, so overflow is impossible.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH.
REQ-032 cmd_ready SHALL deassert for the entire cycle spent in EXEC.

Reset
REQ-033 While rst is high, the block SHALL hold state=IDLE, fifo_count=0, FIFO pointers=0, op_count=0, alu_a=alu_b=0, alu_fn=0, res_valid=0, res_z=0, res_tag=0, res_fn=0, res_dz=0, and cmd_ready=0.
REQ-034 After rst deasserts, cmd_ready SHALL rise at the first clock edge.
REQ-035 A reset asserted during EXEC SHALL discard the in-flight command with no FIFO write and no op_count change, and SHALL flush all FIFO contents.

Verification
REQ-036 Add: a=0x0C, b=0x05, fn=0000, tag=3 with the ALU attached -> cmd_ready low for 1 cycle, res_valid high after edge k+1, res_z=0x11, res_tag=3, res_dz=0, op_count=1.
REQ-037 Hamming weight: a=0x0C, fn=1111 -> res_z=0x02, res_fn=1111.
REQ-038 Fill: res_ready=0 and 5 back-to-back commands with tags 0-4 -> 4 accepted, then cmd_ready=0 with FIFO full; one pop -> cmd_ready returns; results drain in tag order 0,1,2,3,4.
REQ-039 Divide by zero: a=0x0C, b=0x00, fn=0011 -> res_dz=1 and res_z equals the ALU output unchanged; with b=0x05 -> res_dz=0 and res_z=0x02.
REQ-040 Simultaneous push and pop: FIFO holds 1 entry, res_ready=1 while a result is written -> count stays 1 and the new result is at the head.
REQ-041 Reset mid-op: rst pulsed during EXEC with 2 entries queued -> res_valid=0 and op_count=0 immediately; the next command after reset yields op_count=1.
